// File: rtl/blackjack_pkg.sv
// Shared types and card helpers for the blackjack dealer.
// Hand arithmetic honours SOFT_ACE_EN in blackjack_hand_accum.
package blackjack_pkg;

  localparam int CARD_W   = 4;
  localparam int CARD_MIN = 1;
  localparam int CARD_MAX = 10;

  typedef enum logic [2:0] {
    IDLE,
    DEAL,
    PLAYER,
    DEALER,
    DONE
  } state_e;

  // Generator range is 0..15; fold it onto the legal 1..10 card values.
  function automatic logic [CARD_W-1:0] clamp_card(input logic [CARD_W-1:0] c);
    if (c < CARD_W'(CARD_MIN)) return CARD_W'(CARD_MIN);
    if (c > CARD_W'(CARD_MAX)) return CARD_W'(CARD_MAX);
    return c;
  endfunction

endpackage

// File: rtl/blackjack_hand_accum.sv
// One hand: hard-total accumulator plus effective total (current and next-cycle).
// SOFT_ACE_EN defined: an ace counts 11 while that keeps the hand <= BUST_LIMIT.
module blackjack_hand_accum
  import blackjack_pkg::*;
#(
  parameter int TOTAL_W    = 5,
  parameter int BUST_LIMIT = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               add_i,
  input  logic [CARD_W-1:0]  card_i,
  output logic [TOTAL_W-1:0] eff_o,
  output logic [TOTAL_W-1:0] eff_nxt_o
);

  logic [TOTAL_W-1:0] hard_q, hard_d;

  always_comb begin
    hard_d = hard_q;
    if (clr_i)      hard_d = '0;
    else if (add_i) hard_d = hard_q + TOTAL_W'(card_i);
  end

  always_ff @(posedge clk) begin
    if (!rst) hard_q <= '0;
    else      hard_q <= hard_d;
  end

`ifdef SOFT_ACE_EN
  logic               ace_q, ace_d;
  logic [TOTAL_W:0]   soft_q, soft_d;

  always_comb begin
    ace_d = ace_q;
    if (clr_i)                                         ace_d = 1'b0;
    else if (add_i && card_i == CARD_W'(CARD_MIN))     ace_d = 1'b1;
    soft_q    = {1'b0, hard_q} + (TOTAL_W+1)'(10);
    soft_d    = {1'b0, hard_d} + (TOTAL_W+1)'(10);
    eff_o     = (ace_q && soft_q <= (TOTAL_W+1)'(BUST_LIMIT)) ? soft_q[TOTAL_W-1:0] : hard_q;
    eff_nxt_o = (ace_d && soft_d <= (TOTAL_W+1)'(BUST_LIMIT)) ? soft_d[TOTAL_W-1:0] : hard_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) ace_q <= 1'b0;
    else      ace_q <= ace_d;
  end
`else
  assign eff_o     = hard_q;
  assign eff_nxt_o = hard_d;
`endif

endmodule

// File: rtl/blackjack_hand_dealer.sv
// Deals one blackjack round from the free-running card generator: deal, player, dealer, result.
// Soft-ace scoring is selected by SOFT_ACE_EN (see blackjack_hand_accum).
module blackjack_hand_dealer
  import blackjack_pkg::*;
#(
  parameter int TOTAL_W      = 5,
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CARD_W-1:0]  rand_card,
  input  logic               new_game,
  input  logic               hit,
  input  logic               stand,
  output logic               card_valid,
  output logic [CARD_W-1:0]  card_val,
  output logic               card_to_dlr,
  output logic [TOTAL_W-1:0] player_total,
  output logic [TOTAL_W-1:0] dealer_total,
  output logic               busy,
  output logic               win,
  output logic               lose,
  output logic               push
);

  state_e             state_q, state_d;
  logic [1:0]         deal_cnt_q, deal_cnt_d;
  logic               cv_q, cv_d, to_dlr_q, to_dlr_d;
  logic [CARD_W-1:0]  cval_q, cval_d, card;
  logic               win_q, win_d, lose_q, lose_d, push_q, push_d;
  logic               clr, deal_p, deal_d;
  logic [TOTAL_W-1:0] p_eff, p_nxt, d_eff, d_nxt;

  blackjack_hand_accum #(.TOTAL_W(TOTAL_W), .BUST_LIMIT(BUST_LIMIT)) u_player (
    .clk(clk), .rst(rst), .clr_i(clr), .add_i(deal_p), .card_i(card),
    .eff_o(p_eff), .eff_nxt_o(p_nxt)
  );

  blackjack_hand_accum #(.TOTAL_W(TOTAL_W), .BUST_LIMIT(BUST_LIMIT)) u_dealer (
    .clk(clk), .rst(rst), .clr_i(clr), .add_i(deal_d), .card_i(card),
    .eff_o(d_eff), .eff_nxt_o(d_nxt)
  );

  assign card = clamp_card(rand_card);

  always_comb begin
    state_d    = state_q;
    deal_cnt_d = deal_cnt_q;
    clr        = 1'b0;
    deal_p     = 1'b0;
    deal_d     = 1'b0;
    win_d      = win_q;
    lose_d     = lose_q;
    push_d     = push_q;
    // new_game restarts the round from any state, aborting whatever was in flight.
    if (new_game) begin
      clr        = 1'b1;
      state_d    = DEAL;
      deal_cnt_d = '0;
      win_d      = 1'b0;
      lose_d     = 1'b0;
      push_d     = 1'b0;
    end else begin
      case (state_q)
        DEAL: begin
          if (deal_cnt_q[0]) deal_d = 1'b1;
          else               deal_p = 1'b1;
          deal_cnt_d = deal_cnt_q + 2'd1;
          // Player hand is complete before the last (dealer) card; a natural auto-stands.
          if (deal_cnt_q == 2'd3)
            state_d = (p_eff == TOTAL_W'(BUST_LIMIT)) ? DEALER : PLAYER;
        end
        PLAYER: begin
          if (stand) begin
            state_d = DEALER;
          end else if (hit) begin
            deal_p = 1'b1;
            if (p_nxt > TOTAL_W'(BUST_LIMIT)) begin
              state_d = DONE;
              lose_d  = 1'b1;
            end
          end
        end
        DEALER: begin
          if (d_eff < TOTAL_W'(DEALER_STAND)) begin
            deal_d = 1'b1;
          end else begin
            state_d = DONE;
            if (d_eff > TOTAL_W'(BUST_LIMIT) || p_eff > d_eff) win_d  = 1'b1;
            else if (p_eff < d_eff)                            lose_d = 1'b1;
            else                                               push_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    cv_d     = deal_p | deal_d;
    to_dlr_d = deal_d;
    cval_d   = (deal_p | deal_d) ? card : cval_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      deal_cnt_q <= '0;
      cv_q       <= 1'b0;
      cval_q     <= '0;
      to_dlr_q   <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deal_cnt_q <= deal_cnt_d;
      cv_q       <= cv_d;
      cval_q     <= cval_d;
      to_dlr_q   <= to_dlr_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      push_q     <= push_d;
    end
  end

  assign card_valid   = cv_q;
  assign card_val     = cval_q;
  assign card_to_dlr  = to_dlr_q;
  assign player_total = p_eff;
  assign dealer_total = d_eff;
  assign busy         = (state_q == DEAL) || (state_q == DEALER);
  assign win          = win_q;
  assign lose         = lose_q;
  assign push         = push_q;

endmodule

// File: tb/tb_blackjack_hand_dealer.sv
// Bench for blackjack_hand_dealer: directed rounds with literal expectations, then random play
// against a card-list reference model. Expectations follow SOFT_ACE_EN when it is defined.
module tb_blackjack_hand_dealer;

  logic       clk, rst, new_game, hit, stand;
  logic [3:0] rand_card;
  logic       card_valid, card_to_dlr, busy, win, lose, push;
  logic [3:0] card_val;
  logic [4:0] player_total, dealer_total;

  blackjack_hand_dealer dut (
    .clk(clk), .rst(rst), .rand_card(rand_card), .new_game(new_game), .hit(hit), .stand(stand),
    .card_valid(card_valid), .card_val(card_val), .card_to_dlr(card_to_dlr),
    .player_total(player_total), .dealer_total(dealer_total), .busy(busy),
    .win(win), .lose(lose), .push(push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SOFT_ACE_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // Reference model: round phase plus the list of cards in each hand.
  localparam int PH_IDLE = 0, PH_DEAL = 1, PH_PLAY = 2, PH_DLR = 3, PH_DONE = 4;
  int m_ph = PH_IDLE;
  int pc[$], dc[$];
  bit m_cv, m_todlr, m_win, m_lose, m_push;
  int m_cval;

  function automatic int card_of(input int r);
    return (r == 0) ? 1 : (r > 10) ? 10 : r;
  endfunction

  function automatic int hand_tot(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
`ifdef SOFT_ACE_EN
    foreach (q[i]) if (q[i] == 1 && s + 10 <= 21) return s + 10;
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    int c, p, d;
    c    = card_of(int'(rand_card));
    m_cv = 1'b0;
    if (!rst) begin
      m_ph = PH_IDLE; pc.delete(); dc.delete();
      m_cval = 0; m_todlr = 0; m_win = 0; m_lose = 0; m_push = 0;
    end else if (new_game) begin
      m_ph = PH_DEAL; pc.delete(); dc.delete();
      m_win = 0; m_lose = 0; m_push = 0;
    end else begin
      case (m_ph)
        PH_DEAL: begin
          m_cv = 1; m_cval = c;
          m_todlr = (pc.size() > dc.size());
          if (m_todlr) dc.push_back(c); else pc.push_back(c);
          if (pc.size() + dc.size() == 4) m_ph = (hand_tot(pc) == 21) ? PH_DLR : PH_PLAY;
        end
        PH_PLAY: begin
          if (stand) m_ph = PH_DLR;
          else if (hit) begin
            m_cv = 1; m_cval = c; m_todlr = 0; pc.push_back(c);
            if (hand_tot(pc) > 21) begin m_ph = PH_DONE; m_lose = 1; end
          end
        end
        PH_DLR: begin
          p = hand_tot(pc); d = hand_tot(dc);
          if (d < 17) begin
            m_cv = 1; m_cval = c; m_todlr = 1; dc.push_back(c);
          end else begin
            m_ph = PH_DONE;
            if (d > 21 || p > d) m_win = 1;
            else if (p < d)      m_lose = 1;
            else                 m_push = 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("card_valid", int'(card_valid), int'(m_cv));
      if (m_cv) begin
        chk("card_val", int'(card_val), m_cval);
        chk("card_to_dlr", int'(card_to_dlr), int'(m_todlr));
      end
      chk("player_total", int'(player_total), hand_tot(pc));
      chk("dealer_total", int'(dealer_total), hand_tot(dc));
      chk("busy", int'(busy), int'(m_ph == PH_DEAL || m_ph == PH_DLR));
      chk("win", int'(win), int'(m_win));
      chk("lose", int'(lose), int'(m_lose));
      chk("push", int'(push), int'(m_push));
    end
  end

  task automatic cyc(input bit ng, input bit h, input bit s, input int rc, input bit r = 1'b1);
    rst = r; new_game = ng; hit = h; stand = s; rand_card = 4'(rc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic deal4(input int a, input int b, input int c, input int d);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, a); cyc(0, 0, 0, b); cyc(0, 0, 0, c); cyc(0, 0, 0, d);
  endtask

  initial begin
    rst = 1'b0; new_game = 1'b0; hit = 1'b0; stand = 1'b0; rand_card = '0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_ptot", int'(player_total), 0);
    chk("rst_dtot", int'(dealer_total), 0);
    chk("rst_flags", int'({card_valid, busy, win, lose, push}), 0);

    // Dealer draws from 16 to 21 and beats player 20.
    deal4(10, 7, 10, 9);
    chk("t1_ptot", int'(player_total), 20);
    chk("t1_dtot", int'(dealer_total), 16);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 0, 5);
    chk("t1_dcard", int'(card_val), 5);
    chk("t1_dtot21", int'(dealer_total), 21);
    cyc(0, 0, 0, 2);
    chk("t1_lose", int'({win, lose, push}), 3'b010);

    // Player hits into a bust; dealer never draws.
    deal4(10, 6, 5, 10);
    cyc(0, 1, 0, 9);
    chk("t2_ptot", int'(player_total), 24);
    chk("t2_lose", int'(lose), 1);
    cyc(0, 0, 0, 4);
    chk("t2_nocard", int'(card_valid), 0);
    chk("t2_dtot", int'(dealer_total), 16);

    // Dealer stands on 18, tie.
    deal4(9, 10, 9, 8);
    cyc(0, 0, 1, 7);
    cyc(0, 0, 0, 7);
    chk("t3_push", int'({win, lose, push}), 3'b001);
    chk("t3_dtot", int'(dealer_total), 18);

    // Ace + ten: soft natural auto-stands, otherwise hard 11.
    deal4(1, 10, 10, 7);
    chk("t4_ptot", int'(player_total), SOFT ? 21 : 11);
    chk("t4_busy", int'(busy), SOFT ? 1 : 0);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 0, 3);
    chk("t4_result", int'({win, lose, push}), SOFT ? 3'b100 : 3'b010);

    // Clamping, and hit+stand together deals nothing.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_clamp0", int'(card_val), 1);
    cyc(0, 0, 0, 13);
    chk("t5_clamp13", int'(card_val), 10);
    chk("t5_todlr", int'(card_to_dlr), 1);
    cyc(0, 0, 0, 4);
    cyc(0, 0, 0, 15);
    cyc(0, 1, 1, 6);
    chk("t5_nocard", int'(card_valid), 0);
    chk("t5_ptot", int'(player_total), SOFT ? 15 : 5);
    chk("t5_dealer", int'(busy), 1);

    // Reset mid-deal, then abort from PLAYER.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 2);
    cyc(0, 0, 0, 3);
    cyc(0, 0, 0, 4, 0);
    chk("t6_rst_tot", int'(player_total) + int'(dealer_total), 0);
    chk("t6_rst_flags", int'({card_valid, busy, win, lose, push}), 0);
    deal4(2, 3, 4, 5);
    chk("t6_ptot", int'(player_total), 6);
    chk("t6_play_busy", int'(busy), 0);
    cyc(1, 0, 0, 0);
    chk("t6_restart_busy", int'(busy), 1);
    chk("t6_restart_tot", int'(player_total), 0);
    cyc(0, 0, 0, 6);
    chk("t6_redeal", int'(player_total), 6);

    // Random play.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
          int'($urandom_range(0, 15)), $urandom_range(0, 199) != 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
